// File: rtl/wb_commit_queue.sv
// In-order write-back queue: accepts a lane group per cycle and drains
// it onto register-file write ports plus one CSR write port.
module wb_commit_queue #(
  parameter int NUM_LANES  = 2,
  parameter int NUM_WPORTS = 2,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic [NUM_LANES-1:0]    in_valid,
  output logic                    in_ready,
  input  logic [5*NUM_LANES-1:0]  in_rd,
  input  logic [32*NUM_LANES-1:0] in_reg_data,
  input  logic [NUM_LANES-1:0]    in_is_csr,
  input  logic [12*NUM_LANES-1:0] in_csr_addr,
  input  logic [32*NUM_LANES-1:0] in_csr_data,
  output logic [NUM_WPORTS-1:0]   reg_w_enabled,
  output logic [5*NUM_WPORTS-1:0] reg_w_addr,
  output logic [32*NUM_WPORTS-1:0] reg_w_data,
  output logic                    csr_w_enabled,
  output logic [11:0]             csr_w_addr,
  output logic [31:0]             csr_w_data,
  output logic [CNT_W-1:0]        retire_count,
  output logic                    completed
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [OW-1:0] occ_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        is_csr;
    logic [11:0] csr_addr;
    logic [31:0] csr_data;
  } wb_entry_t;

  ptr_t      head;
  ptr_t      tail;
  occ_t      occ;
  wb_entry_t mem [DEPTH];

  wb_entry_t             lane [NUM_LANES];
  ptr_t                  lane_slot [NUM_LANES];
  logic [NUM_LANES-1:0]  lane_we;
  logic                  enq;
  occ_t                  n_enq;

  wb_entry_t             grp [NUM_WPORTS];
  logic [NUM_WPORTS-1:0] take;
  occ_t                  k;

  assign in_ready  = (occ_t'(DEPTH) - occ) >= occ_t'(NUM_LANES);
  assign completed = (occ == '0) && !(|in_valid);
  assign enq       = in_ready && !flush && (|in_valid);

  // Valid lanes are packed in lane order onto consecutive tail slots.
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane[i].rd       = in_rd[5*i +: 5];
      lane[i].data     = in_reg_data[32*i +: 32];
      lane[i].is_csr   = in_is_csr[i];
      lane[i].csr_addr = in_csr_addr[12*i +: 12];
      lane[i].csr_data = in_csr_data[32*i +: 32];
      lane_slot[i]     = tail + ptr_t'(n_enq);
      lane_we[i]       = enq && in_valid[i];
      if (in_valid[i]) begin
        n_enq = n_enq + occ_t'(1);
      end
    end
    if (!enq) begin
      n_enq = '0;
    end
  end

  // Drain group stops at the queue end or before a second CSR entry.
  always_comb begin
    logic csr_seen;
    logic stop;
    take     = '0;
    k        = '0;
    csr_seen = 1'b0;
    stop     = 1'b0;
    for (int j = 0; j < NUM_WPORTS; j++) begin
      grp[j] = mem[head + ptr_t'(j)];
      if (stop || j >= int'(occ)) begin
        stop = 1'b1;
      end else if (grp[j].is_csr && csr_seen) begin
        stop = 1'b1;
      end else begin
        take[j]  = 1'b1;
        k        = k + occ_t'(1);
        csr_seen = csr_seen | grp[j].is_csr;
      end
    end
  end

  // Older duplicates of a younger same-rd entry lose their enable.
  always_comb begin
    logic en;
    reg_w_enabled = '0;
    reg_w_addr    = '0;
    reg_w_data    = '0;
    csr_w_enabled = 1'b0;
    csr_w_addr    = '0;
    csr_w_data    = '0;
    for (int j = 0; j < NUM_WPORTS; j++) begin
      en = take[j] && !flush && (grp[j].rd != 5'd0);
      for (int m = 0; m < NUM_WPORTS; m++) begin
        if (m > j && take[m] && grp[m].rd == grp[j].rd) begin
          en = 1'b0;
        end
      end
      reg_w_enabled[j] = en;
      if (en) begin
        reg_w_addr[5*j +: 5]  = grp[j].rd;
        reg_w_data[32*j +: 32] = grp[j].data;
      end
      if (take[j] && grp[j].is_csr && !flush) begin
        csr_w_enabled = 1'b1;
        csr_w_addr    = grp[j].csr_addr;
        csr_w_data    = grp[j].csr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head         <= '0;
      tail         <= '0;
      occ          <= '0;
      retire_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_we[i]) begin
          mem[lane_slot[i]] <= lane[i];
        end
      end
      tail         <= tail + ptr_t'(n_enq);
      head         <= head + ptr_t'(k);
      occ          <= occ + n_enq - k;
      retire_count <= retire_count + CNT_W'(k);
    end
  end

endmodule
